// File: rtl/mmio_clint.sv
// Core-local interruptor: prescaled 64-bit mtime, per-hart mtimecmp and msip,
// exposed as 32-bit registers with one-cycle registered request timing.
module mmio_clint #(
    parameter int NUM_HARTS = 1,
    parameter int PRESC_W   = 8,
    parameter int ADDR_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 IN_re,
    input  logic [ADDR_W-1:0]    IN_raddr,
    output logic [31:0]          OUT_rdata,

    input  logic                 IN_we,
    input  logic [ADDR_W-1:0]    IN_waddr,
    input  logic [31:0]          IN_wdata,
    input  logic [3:0]           IN_wmask,

    output logic                 OUT_rbusy,
    output logic                 OUT_wbusy,

    output logic [63:0]          OUT_mtime,
    output logic [NUM_HARTS-1:0] OUT_timerIrq,
    output logic [NUM_HARTS-1:0] OUT_softIrq
);

    localparam int CMP_BASE = 4 + NUM_HARTS;

    logic                 reReg;
    logic                 weReg;
    logic [ADDR_W-1:0]    raddrReg;
    logic [ADDR_W-1:0]    waddrReg;
    logic [31:0]          wdataReg;
    logic [3:0]           wmaskReg;

    logic [63:0]          mtime;
    logic [31:0]          hiShadow;
    logic [PRESC_W-1:0]   pcnt;
    logic [PRESC_W-1:0]   div;
    logic                 en;
    logic                 tick;

    logic [NUM_HARTS-1:0]        msip;
    logic [NUM_HARTS-1:0][63:0]  mtimecmp;

    logic [31:0]          bitMask;
    logic                 wrMtLo;
    logic                 wrMtHi;
    logic                 wrCtrl;
    logic [NUM_HARTS-1:0] wrMsip;
    logic [NUM_HARTS-1:0] wrCmpLo;
    logic [NUM_HARTS-1:0] wrCmpHi;
    logic                 rdMtLo;
    logic [31:0]          rdNext;

    assign OUT_rbusy   = 1'b0;
    assign OUT_wbusy   = 1'b0;
    assign OUT_mtime   = mtime;
    assign OUT_softIrq = msip;

    function automatic logic [31:0] mergeLanes(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [31:0] mask
    );
        mergeLanes = (old & ~mask) | (data & mask);
    endfunction

    // Request capture; everything else acts on these one edge later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reReg    <= 1'b1;
            weReg    <= 1'b1;
            raddrReg <= '0;
            waddrReg <= '0;
            wdataReg <= '0;
            wmaskReg <= '0;
        end else begin
            reReg    <= IN_re;
            weReg    <= IN_we;
            raddrReg <= IN_raddr;
            waddrReg <= IN_waddr;
            wdataReg <= IN_wdata;
            wmaskReg <= IN_wmask;
        end
    end

    assign bitMask = {{8{wmaskReg[3]}}, {8{wmaskReg[2]}},
                      {8{wmaskReg[1]}}, {8{wmaskReg[0]}}};

    always_comb begin
        wrMtLo  = 1'b0;
        wrMtHi  = 1'b0;
        wrCtrl  = 1'b0;
        wrMsip  = '0;
        wrCmpLo = '0;
        wrCmpHi = '0;
        if (!weReg) begin
            unique case (1'b1)
                (waddrReg == ADDR_W'(0)): wrMtLo = 1'b1;
                (waddrReg == ADDR_W'(1)): wrMtHi = 1'b1;
                (waddrReg == ADDR_W'(2)): wrCtrl = 1'b1;
                default: ;
            endcase
            for (int h = 0; h < NUM_HARTS; h++) begin
                wrMsip[h]  = (waddrReg == ADDR_W'(4 + h));
                wrCmpLo[h] = (waddrReg == ADDR_W'(CMP_BASE + 2*h));
                wrCmpHi[h] = (waddrReg == ADDR_W'(CMP_BASE + 2*h + 1));
            end
        end
    end

    assign tick = en && (pcnt == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (wrCtrl) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en  <= 1'b1;
            div <= '0;
        end else if (wrCtrl) begin
            if (wmaskReg[0])
                en <= wdataReg[0];
            div <= (div & ~bitMask[8 +: PRESC_W])
                 | (wdataReg[8 +: PRESC_W] & bitMask[8 +: PRESC_W]);
        end
    end

    // A software write to either half wins over the tick in that cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= '0;
        end else if (wrMtLo) begin
            mtime[31:0] <= mergeLanes(mtime[31:0], wdataReg, bitMask);
        end else if (wrMtHi) begin
            mtime[63:32] <= mergeLanes(mtime[63:32], wdataReg, bitMask);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp <= '1;
            msip     <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (wrCmpLo[h])
                    mtimecmp[h][31:0] <=
                        mergeLanes(mtimecmp[h][31:0], wdataReg, bitMask);
                if (wrCmpHi[h])
                    mtimecmp[h][63:32] <=
                        mergeLanes(mtimecmp[h][63:32], wdataReg, bitMask);
                if (wrMsip[h] && wmaskReg[0])
                    msip[h] <= wdataReg[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OUT_timerIrq <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++)
                OUT_timerIrq[h] <= (mtime >= mtimecmp[h]);
        end
    end

    assign rdMtLo = !reReg && (raddrReg == ADDR_W'(0));

    always_comb begin
        rdNext = '0;
        unique case (1'b1)
            (raddrReg == ADDR_W'(0)): rdNext = mtime[31:0];
            (raddrReg == ADDR_W'(1)): rdNext = hiShadow;
            (raddrReg == ADDR_W'(2)): begin
                rdNext[0]            = en;
                rdNext[8 +: PRESC_W] = div;
            end
            (raddrReg == ADDR_W'(3)): begin
                rdNext[0 +: NUM_HARTS]  = OUT_timerIrq;
                rdNext[16 +: NUM_HARTS] = msip;
            end
            default: begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (raddrReg == ADDR_W'(4 + h))
                        rdNext = {31'b0, msip[h]};
                    if (raddrReg == ADDR_W'(CMP_BASE + 2*h))
                        rdNext = mtimecmp[h][31:0];
                    if (raddrReg == ADDR_W'(CMP_BASE + 2*h + 1))
                        rdNext = mtimecmp[h][63:32];
                end
            end
        endcase
    end

    // Low-word read snapshots the high word so a lo/hi pair is coherent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OUT_rdata <= '0;
            hiShadow  <= '0;
        end else begin
            if (!reReg)
                OUT_rdata <= rdNext;
            if (rdMtLo)
                hiShadow <= mtime[63:32];
        end
    end

endmodule

// File: tb/tb_mmio_clint.sv
// Directed bench for mmio_clint with two harts.
// Drives and samples on the falling edge.
module tb_mmio_clint;

    localparam int NH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          IN_re = 1'b1;
    logic [5:0]    IN_raddr = '0;
    logic [31:0]   OUT_rdata;
    logic          IN_we = 1'b1;
    logic [5:0]    IN_waddr = '0;
    logic [31:0]   IN_wdata = '0;
    logic [3:0]    IN_wmask = '0;
    logic          OUT_rbusy;
    logic          OUT_wbusy;
    logic [63:0]   OUT_mtime;
    logic [NH-1:0] OUT_timerIrq;
    logic [NH-1:0] OUT_softIrq;

    int checks = 0;
    int failures = 0;
    logic [31:0] rv;
    logic [63:0] m0;

    mmio_clint #(.NUM_HARTS(NH), .PRESC_W(8), .ADDR_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .IN_re(IN_re),
        .IN_raddr(IN_raddr),
        .OUT_rdata(OUT_rdata),
        .IN_we(IN_we),
        .IN_waddr(IN_waddr),
        .IN_wdata(IN_wdata),
        .IN_wmask(IN_wmask),
        .OUT_rbusy(OUT_rbusy),
        .OUT_wbusy(OUT_wbusy),
        .OUT_mtime(OUT_mtime),
        .OUT_timerIrq(OUT_timerIrq),
        .OUT_softIrq(OUT_softIrq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d,
                      input logic [3:0] m);
        IN_we = 1'b0;
        IN_waddr = a;
        IN_wdata = d;
        IN_wmask = m;
        @(negedge clk);
        IN_we = 1'b1;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        IN_re = 1'b0;
        IN_raddr = a;
        @(negedge clk);
        IN_re = 1'b1;
        @(negedge clk);
        d = OUT_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        chk("rst_mtime", OUT_mtime, 64'd0);
        chk("rst_rdata", OUT_rdata, 64'd0);
        chk("rst_tirq", OUT_timerIrq, 64'd0);
        chk("rst_sirq", OUT_softIrq, 64'd0);
        chk("busy", {OUT_rbusy, OUT_wbusy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // free-running, div=0
        repeat (10) @(negedge clk);
        chk("idle10", OUT_mtime, 64'd10);
        chk("idle_tirq", OUT_timerIrq, 64'd0);
        rd(6'd3, rv);
        chk("status0", rv, 64'd0);
        rd(6'd1, rv);
        chk("shadow_rst", rv, 64'd0);
        rd(6'd2, rv);
        chk("ctrl_rst", rv, 64'h1);
        rd(6'd6, rv);
        chk("cmp0_rst", rv, 64'hFFFF_FFFF);

        // prescaler div=3
        wr(6'd2, 32'h0000_0301, 4'hF);
        @(negedge clk);
        m0 = OUT_mtime;
        repeat (3) @(negedge clk);
        chk("presc3", OUT_mtime - m0, 64'd0);
        @(negedge clk);
        chk("presc4", OUT_mtime - m0, 64'd1);
        repeat (36) @(negedge clk);
        chk("presc40", OUT_mtime - m0, 64'd10);
        rd(6'd2, rv);
        chk("ctrl_rd", rv, 64'h301);

        // timer compare on hart 1
        wr(6'd2, 32'h1, 4'hF);
        wr(6'd0, 32'd100, 4'hF);
        wr(6'd8, 32'd110, 4'hF);
        wr(6'd9, 32'd0, 4'hF);
        repeat (9) @(negedge clk);
        chk("cmp_mtime", OUT_mtime, 64'd110);
        chk("cmp_pre", OUT_timerIrq, 64'b00);
        @(negedge clk);
        chk("cmp_rise", OUT_timerIrq, 64'b10);
        rd(6'd3, rv);
        chk("status_t", rv, 64'h2);
        wr(6'd9, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        chk("cmp_hold", OUT_timerIrq, 64'b10);
        @(negedge clk);
        chk("cmp_fall", OUT_timerIrq, 64'b00);

        // wrap and write-over-tick
        wr(6'd0, 32'hFFFF_FFFF, 4'hF);
        wr(6'd1, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        chk("all_ones", OUT_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("wrap", OUT_mtime, 64'd0);
        chk("irq_eq", OUT_timerIrq, 64'b11);
        wr(6'd0, 32'h1234, 4'hF);
        chk("irq_clr", OUT_timerIrq, 64'b00);
        @(negedge clk);
        chk("wr_no_inc", OUT_mtime, 64'h1234);
        wr(6'd0, 32'hAABB_CCDD, 4'b0010);
        @(negedge clk);
        chk("lane1", OUT_mtime, 64'hCC35);

        // atomic 64-bit read
        wr(6'd1, 32'h1, 4'hF);
        wr(6'd0, 32'hFFFF_FFFF, 4'hF);
        rd(6'd0, rv);
        chk("atom_lo", rv, 64'hFFFF_FFFF);
        chk("atom_live", OUT_mtime, 64'h2_0000_0000);
        repeat (3) @(negedge clk);
        rd(6'd1, rv);
        chk("atom_hi", rv, 64'h1);
        chk("live_hi", OUT_mtime[63:32], 64'h2);

        // register readback and unmapped words
        rd(6'd8, rv);
        chk("cmp1_lo", rv, 64'd110);
        rd(6'd9, rv);
        chk("cmp1_hi", rv, 64'hFFFF_FFFF);
        wr(6'd20, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        rd(6'd20, rv);
        chk("unmap20", rv, 64'd0);
        rd(6'd10, rv);
        chk("unmap10", rv, 64'd0);

        // software interrupts
        wr(6'd4, 32'h1, 4'b0001);
        chk("msip_pre", OUT_softIrq, 64'b00);
        @(negedge clk);
        chk("msip_set", OUT_softIrq, 64'b01);
        rd(6'd3, rv);
        chk("status_s", rv, 64'h0001_0000);
        wr(6'd4, 32'h0, 4'b0010);
        @(negedge clk);
        chk("msip_mask", OUT_softIrq, 64'b01);
        wr(6'd5, 32'h1, 4'b0001);
        @(negedge clk);
        chk("msip1", OUT_softIrq, 64'b11);
        rd(6'd4, rv);
        chk("msip_rd", rv, 64'h1);

        // read-before-write on the same word
        IN_re = 1'b0;
        IN_raddr = 6'd5;
        IN_we = 1'b0;
        IN_waddr = 6'd5;
        IN_wdata = 32'h0;
        IN_wmask = 4'b0001;
        @(negedge clk);
        IN_re = 1'b1;
        IN_we = 1'b1;
        @(negedge clk);
        chk("rbw_data", OUT_rdata, 64'h1);
        chk("rbw_irq", OUT_softIrq, 64'b01);
        repeat (3) @(negedge clk);
        chk("rdata_hold", OUT_rdata, 64'h1);

        // reset while a write is pending
        wr(6'd5, 32'h1, 4'b0001);
        rst = 1'b1;
        #1;
        chk("mid_mtime", OUT_mtime, 64'd0);
        chk("mid_rdata", OUT_rdata, 64'd0);
        chk("mid_tirq", OUT_timerIrq, 64'd0);
        chk("mid_sirq", OUT_softIrq, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_sirq", OUT_softIrq, 64'd0);
        chk("post_mtime", OUT_mtime, 64'd1);
        rd(6'd2, rv);
        chk("post_ctrl", rv, 64'h1);
        rd(6'd9, rv);
        chk("post_cmp", rv, 64'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
